// File: rtl/cp0_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_int_ctrl
// Brief    : Coprocessor-0 interrupt controller (SR, Cause, EPC, PRId) with
//            level-tracked hardware interrupt pending bits and eret support.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_int_ctrl #(
   parameter logic [31:0] PRID = 32'h0000_0007
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   input  logic [31:0] din,
   input  logic        we,
   input  logic [29:0] pc,
   input  logic [5:0]  hwint,
   input  logic        exl_set,
   input  logic        exl_clr,
   output logic        intreq,
   output logic [31:0] epc,
   output logic [31:0] dout
);

   localparam logic [4:0] c_reg_sr    = 5'd12;
   localparam logic [4:0] c_reg_cause = 5'd13;
   localparam logic [4:0] c_reg_epc   = 5'd14;
   localparam logic [4:0] c_reg_prid  = 5'd15;

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic [5:0]  r_ip;
   logic [29:0] r_epc;

   logic        w_wr_sr;
   logic        w_wr_epc;
   logic [31:0] w_sr;
   logic [31:0] w_cause;

   assign w_wr_sr  = we && (a2 == c_reg_sr);
   assign w_wr_epc = we && (a2 == c_reg_epc);

   // IM and IE follow software writes; EXL is owned by the pipeline first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_im  <= 6'd0;
         r_ie  <= 1'b0;
         r_exl <= 1'b0;
      end else begin
         if (w_wr_sr) begin
            r_im <= din[15:10];
            r_ie <= din[0];
         end
         if (exl_set)
            r_exl <= 1'b1;
         else if (exl_clr)
            r_exl <= 1'b0;
         else if (w_wr_sr)
            r_exl <= din[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_epc <= 30'd0;
      end else if (exl_set) begin
         r_epc <= pc;
      end else if (w_wr_epc) begin
         r_epc <= din[31:2];
      end
   end

   // Pending bits mirror the lines each cycle; nothing is held once a line drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ip <= 6'd0;
      else
         r_ip <= hwint;
   end

   assign intreq  = (|(r_ip & r_im)) & r_ie & ~r_exl;
   assign epc     = {r_epc, 2'b00};
   assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
   assign w_cause = {16'd0, r_ip, 10'd0};

   always_comb begin
      dout = 32'd0;
      case (a1)
         c_reg_sr:    dout = w_sr;
         c_reg_cause: dout = w_cause;
         c_reg_epc:   dout = {r_epc, 2'b00};
         c_reg_prid:  dout = PRID;
         default:     dout = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cp0_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_int_ctrl
// Brief    : Scoreboard bench for cp0_int_ctrl; stimulus queues expectations,
//            a negedge monitor pops and compares them against the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_int_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [31:0] din;
   logic        we;
   logic [29:0] pc;
   logic [5:0]  hwint;
   logic        exl_set;
   logic        exl_clr;
   logic        intreq;
   logic [31:0] epc;
   logic [31:0] dout;

   cp0_int_ctrl #(.PRID(32'h0000_0007)) dut (
      .clk(clk), .rst(rst), .a1(a1), .a2(a2), .din(din), .we(we), .pc(pc),
      .hwint(hwint), .exl_set(exl_set), .exl_clr(exl_clr),
      .intreq(intreq), .epc(epc), .dout(dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;   // 0 = dout, 1 = intreq, 2 = epc
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e = q.pop_front();
         case (e.sel)
            0:       act = dout;
            1:       act = {31'd0, intreq};
            default: act = epc;
         endcase
         checks++;
         if (act !== e.exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic push(input string name, input int sel, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      q.push_back(e);
   endtask

   task automatic rd(input logic [4:0] r, input logic [31:0] exp, input string name);
      a1 = r;
      push(name, 0, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; exl_set = 1'b0; exl_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; a1 = 5'd0; a2 = 5'd0; din = 32'd0; we = 1'b0; pc = 30'd0;
      hwint = 6'd0; exl_set = 1'b0; exl_clr = 1'b0;

      // Reset state reads
      rd(5'd12, 32'h0, "rst_sr"); push("rst_intreq", 1, 32'h0); push("rst_epc", 2, 32'h0);
      tick();
      rd(5'd13, 32'h0, "rst_cause"); tick();
      rd(5'd14, 32'h0, "rst_epcreg"); tick();
      rd(5'd15, 32'h7, "rst_prid"); tick();
      rst = 1'b0;

      // Enable and fire
      hwint = 6'b000001; we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
      push("pre_intreq", 1, 32'h0);
      tick();
      idle();
      rd(5'd13, 32'h0000_0400, "cause_ip2"); push("fire_intreq", 1, 32'h1);
      tick();

      // Entry
      exl_set = 1'b1; pc = 30'h0000_0C05;
      tick();
      idle();
      rd(5'd12, 32'h0000_0403, "entry_sr"); push("entry_intreq", 1, 32'h0);
      push("entry_epc", 2, 32'h0000_3014);
      tick();
      exl_clr = 1'b1;
      tick();
      idle();
      push("eret_intreq", 1, 32'h1);
      tick();

      // exl_set beats mtc0 EPC
      exl_set = 1'b1; pc = 30'h1; we = 1'b1; a2 = 5'd14; din = 32'h1234_5678;
      tick();
      idle();
      push("coll_epc", 2, 32'h0000_0004); push("coll_intreq", 1, 32'h0);
      tick();
      exl_clr = 1'b1;
      tick();
      idle();

      // exl_set beats exl_clr
      exl_set = 1'b1; exl_clr = 1'b1; pc = 30'h2;
      tick();
      idle();
      rd(5'd12, 32'h0000_0403, "setclr_sr"); push("setclr_epc", 2, 32'h0000_0008);
      push("setclr_intreq", 1, 32'h0);
      tick();

      // exl_clr beats mtc0 SR.EXL=1
      exl_clr = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0403;
      tick();
      idle();
      rd(5'd12, 32'h0000_0401, "clrwr_sr"); push("clrwr_intreq", 1, 32'h1);
      tick();

      // exl_set beats mtc0 SR.EXL=0, IM/IE still written
      exl_set = 1'b1; pc = 30'h3; we = 1'b1; a2 = 5'd12; din = 32'h0000_0801;
      tick();
      idle();
      rd(5'd12, 32'h0000_0803, "setwr_sr"); push("setwr_epc", 2, 32'h0000_000C);
      tick();
      exl_clr = 1'b1;
      tick();
      idle();

      // Masking
      hwint = 6'b100000; we = 1'b1; a2 = 5'd12; din = 32'h0000_7C01;
      tick();
      idle();
      rd(5'd13, 32'h0000_8000, "mask_cause"); push("mask_intreq", 1, 32'h0);
      tick();
      we = 1'b1; a2 = 5'd12; din = 32'h0000_8001;
      tick();
      idle();
      rd(5'd12, 32'h0000_8001, "unmask_sr"); push("unmask_intreq", 1, 32'h1);
      tick();

      // Ignored writes, normal EPC write, unmapped read
      we = 1'b1; a2 = 5'd13; din = 32'hFFFF_FFFF;
      tick();
      a2 = 5'd7;
      tick();
      we = 1'b1; a2 = 5'd14; din = 32'hABCD_1237;
      tick();
      idle();
      rd(5'd13, 32'h0000_8000, "cause_nowr"); push("epc_wr", 2, 32'hABCD_1234);
      tick();
      rd(5'd7, 32'h0, "reg7_read"); tick();
      rd(5'd14, 32'hABCD_1234, "epc_read"); push("pre_arst_intreq", 1, 32'h1);
      tick();

      // Asynchronous reset between edges
      a1 = 5'd12;
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      push("arst_intreq", 1, 32'h0); push("arst_epc", 2, 32'h0);
      rd(5'd12, 32'h0, "arst_sr");
      tick();

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
